mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    // Arbiter ownership of the shared memory port
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

    // Default number of consecutive data grants tolerated while fetch waits
    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data port share one
// registered memory request channel. Data port normally wins; fetch is
// forced through after STARVE_LIMIT consecutive data grants while it waits.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             mem_valid_q, mem_valid_d;
    logic             mem_we_q, mem_we_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             fetch_forced;

    // Fetch overrides the data port only once it has been starved long enough
    assign fetch_forced = if_req && (starve_cnt_q == LIMIT);

    // Next-state, grant selection and memory request field staging
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (dm_req && !fetch_forced) begin
                    state_d     = DM_BUSY;
                    mem_valid_d = 1'b1;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_be;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    // Count only data grants that made fetch wait
                    if (!if_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != LIMIT) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (if_req) begin
                    state_d      = IF_BUSY;
                    mem_valid_d  = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_be_d     = 4'hF;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = '0;
                    starve_cnt_d = '0;
                end
            end
            IF_BUSY, DM_BUSY: begin
                // Request fields stay frozen until memory completes
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // State, starvation counter and registered memory request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Completion is combinational from mem_ready; ready in IDLE is ignored
    assign if_ack   = (state_q == IF_BUSY) && mem_ready;
    assign dm_ack   = (state_q == DM_BUSY) && mem_ready;
    assign if_rdata = if_ack ? mem_rdata : '0;
    assign dm_rdata = dm_ack ? mem_rdata : '0;

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_be = '0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_valid;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall_if;
    logic        stall_mem;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", mem_valid); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", mem_we); end
        checks++; if (mem_be !== 4'h0) begin failures++; $display("FAIL rst_be got=%h exp=0", mem_be); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
        checks++; if (if_ack !== 1'b0 || dm_ack !== 1'b0) begin failures++; $display("FAIL rst_acks got=%b%b exp=00", if_ack, dm_ack); end
        checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0", if_rdata, dm_rdata); end
        tick();
        tick();
        mem_ready = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        dm_wdata = 32'hFFFF_FFFF;
        dm_be = 4'h3;
        dm_we = 1'b1;
        if_req = 1'b1;
        if_addr = 32'h100;
        #1;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL fetch_pre_valid got=%b exp=0", mem_valid); end
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL fetch_pre_stall got=%b exp=1", stall_if); end
        tick();
        checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL fetch_valid got=%b exp=1", mem_valid); end
        checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL fetch_addr got=%h exp=100", mem_addr); end
        checks++; if (mem_we !== 1'b0 || mem_be !== 4'hF || mem_wdata !== 32'h0) begin
            failures++; $display("FAIL fetch_fields got=we%b be%h wd%h exp=we0 beF wd0", mem_we, mem_be, mem_wdata); end
        checks++; if (if_ack !== 1'b0) begin failures++; $display("FAIL fetch_early_ack got=%b exp=0", if_ack); end
        mem_ready = 1'b1;
        mem_rdata = 32'h0050_0093;
        #1;
        checks++; if (if_ack !== 1'b1) begin failures++; $display("FAIL fetch_ack got=%b exp=1", if_ack); end
        checks++; if (if_rdata !== 32'h0050_0093) begin failures++; $display("FAIL fetch_rdata got=%h exp=00500093", if_rdata); end
        checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL fetch_stall_ack got=%b exp=0", stall_if); end
        checks++; if (dm_ack !== 1'b0 || dm_rdata !== 32'h0) begin failures++; $display("FAIL fetch_dm_quiet got=%b %h exp=0 0", dm_ack, dm_rdata); end
        tick();
        mem_ready = 1'b0;
        if_req = 1'b0;
        dm_we = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL fetch_done_valid got=%b exp=0", mem_valid); end
        checks++; if (if_ack !== 1'b0 || if_rdata !== 32'h0) begin failures++; $display("FAIL fetch_done_ack got=%b %h exp=0 0", if_ack, if_rdata); end
    endtask

    task automatic test_simultaneous();
        if_addr = 32'h200;
        dm_addr = 32'h400;
        dm_we = 1'b0;
        dm_be = 4'hC;
        dm_wdata = 32'h0;
        if_req = 1'b1;
        dm_req = 1'b1;
        #1;
        checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin failures++; $display("FAIL sim_stalls got=%b%b exp=11", stall_if, stall_mem); end
        tick();
        checks++; if (mem_addr !== 32'h400 || mem_be !== 4'hC) begin failures++; $display("FAIL sim_dm_first got=%h %h exp=400 C", mem_addr, mem_be); end
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        #1;
        checks++; if (dm_ack !== 1'b1 || if_ack !== 1'b0) begin failures++; $display("FAIL sim_dm_ack got=dm%b if%b exp=dm1 if0", dm_ack, if_ack); end
        checks++; if (dm_rdata !== 32'hCAFE_0001) begin failures++; $display("FAIL sim_dm_rdata got=%h exp=cafe0001", dm_rdata); end
        checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b0) begin failures++; $display("FAIL sim_stall_mid got=%b%b exp=10", stall_if, stall_mem); end
        tick();
        mem_ready = 1'b0;
        dm_req = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL sim_idle_gap got=%b exp=0", mem_valid); end
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL sim_if_still_stalled got=%b exp=1", stall_if); end
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h200 || mem_be !== 4'hF) begin
            failures++; $display("FAIL sim_if_grant got=v%b %h %h exp=v1 200 F", mem_valid, mem_addr, mem_be); end
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_0002;
        #1;
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'hCAFE_0002) begin failures++; $display("FAIL sim_if_ack got=%b %h exp=1 cafe0002", if_ack, if_rdata); end
        tick();
        mem_ready = 1'b0;
        if_req = 1'b0;
        #1;
    endtask

    task automatic test_wait_states();
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_be = 4'b0011;
        dm_addr = 32'h2000;
        dm_wdata = 32'hDEAD_BEEF;
        tick();
        for (int w = 0; w < 3; w++) begin
            checks++; if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 ||
                          mem_addr !== 32'h2000 || mem_wdata !== 32'hDEAD_BEEF) begin
                failures++; $display("FAIL wait_stable%0d got=v%b we%b be%h a%h d%h exp=v1 we1 be3 a2000 ddeadbeef",
                                     w, mem_valid, mem_we, mem_be, mem_addr, mem_wdata); end
            checks++; if (dm_ack !== 1'b0) begin failures++; $display("FAIL wait_no_ack%0d got=%b exp=0", w, dm_ack); end
            if (w == 0) begin
                // Requester withdraws; the transaction must still complete
                dm_req = 1'b0;
                dm_addr = 32'h9999;
                dm_wdata = 32'h0;
                dm_be = 4'hF;
            end
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_00AA;
        #1;
        checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'h0000_00AA) begin failures++; $display("FAIL wait_ack got=%b %h exp=1 000000aa", dm_ack, dm_rdata); end
        tick();
        mem_ready = 1'b0;
        #1;
        checks++; if (dm_ack !== 1'b0 || mem_valid !== 1'b0) begin failures++; $display("FAIL wait_single_pulse got=ack%b v%b exp=0 0", dm_ack, mem_valid); end
    endtask

    task automatic test_starvation();
        logic        exp_we;
        logic [31:0] exp_addr;
        if_addr = 32'h500;
        if_req = 1'b1;
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_be = 4'hF;
        dm_wdata = 32'h1000;
        dm_addr = 32'h3000;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_we = (k < 4);
            exp_addr = (k < 4) ? (32'h3000 + 32'(4 * k)) : 32'h500;
            checks++; if (mem_valid !== 1'b1 || mem_we !== exp_we || mem_addr !== exp_addr) begin
                failures++; $display("FAIL starve_grant%0d got=v%b we%b a%h exp=v1 we%b a%h", k, mem_valid, mem_we, mem_addr, exp_we, exp_addr); end
            mem_ready = 1'b1;
            mem_rdata = 32'(k);
            #1;
            checks++; if (dm_ack !== exp_we || if_ack !== !exp_we) begin
                failures++; $display("FAIL starve_ack%0d got=dm%b if%b exp=dm%b if%b", k, dm_ack, if_ack, exp_we, !exp_we); end
            tick();
            mem_ready = 1'b0;
            if (k < 4) dm_addr = dm_addr + 32'd4;
            else if_req = 1'b0;
            #1;
            checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL starve_gap%0d got=%b exp=0", k, mem_valid); end
        end
        // Counter cleared by the fetch grant, so data wins again
        if_req = 1'b1;
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h3010) begin failures++; $display("FAIL starve_cleared got=we%b a%h exp=we1 a3010", mem_we, mem_addr); end
        mem_ready = 1'b1;
        #1;
        tick();
        mem_ready = 1'b0;
        dm_req = 1'b0;
        tick();
        checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h500) begin failures++; $display("FAIL starve_last_fetch got=we%b a%h exp=we0 a500", mem_we, mem_addr); end
        mem_ready = 1'b1;
        #1;
        tick();
        mem_ready = 1'b0;
        if_req = 1'b0;
        #1;
    endtask

    task automatic test_spurious_ready();
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0BAD;
        #1;
        checks++; if (if_ack !== 1'b0 || dm_ack !== 1'b0) begin failures++; $display("FAIL spur_ack got=%b%b exp=00", if_ack, dm_ack); end
        checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin failures++; $display("FAIL spur_rdata got=%h/%h exp=0", if_rdata, dm_rdata); end
        tick();
        tick();
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL spur_valid got=%b exp=0", mem_valid); end
        mem_ready = 1'b0;
        if_req = 1'b1;
        if_addr = 32'h700;
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h700) begin failures++; $display("FAIL spur_then_fetch got=v%b a%h exp=v1 a700", mem_valid, mem_addr); end
        mem_ready = 1'b1;
        #1;
        checks++; if (if_ack !== 1'b1) begin failures++; $display("FAIL spur_fetch_ack got=%b exp=1", if_ack); end
        tick();
        mem_ready = 1'b0;
        if_req = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid();
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_be = 4'hF;
        dm_addr = 32'h6000;
        dm_wdata = 32'h55;
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h6000) begin failures++; $display("FAIL rmid_busy got=v%b a%h exp=v1 a6000", mem_valid, mem_addr); end
        #2;
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", mem_valid); end
        checks++; if (mem_we !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++; $display("FAIL rmid_fields got=we%b be%h a%h d%h exp=0", mem_we, mem_be, mem_addr, mem_wdata); end
        checks++; if (dm_ack !== 1'b0) begin failures++; $display("FAIL rmid_ack got=%b exp=0", dm_ack); end
        dm_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++; if (dm_ack !== 1'b0 || if_ack !== 1'b0) begin failures++; $display("FAIL rmid_post_ack got=%b%b exp=00", dm_ack, if_ack); end
        tick();
        checks++; if (mem_valid !== 1'b0 || dm_ack !== 1'b0) begin failures++; $display("FAIL rmid_post_idle got=v%b ack%b exp=0 0", mem_valid, dm_ack); end
        mem_ready = 1'b0;
        #1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_wait_states();
        test_starvation();
        test_spurious_ready();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
